// File: rtl/pp_axi_mem_model_if.sv
// pp_axi_mem_model_if: AXI channel bundle between the graphics core's AXI
// master port and the pp_axi_mem_model slave memory.
// Signal names keep the i_/o_ prefixes as seen from the memory model.
interface pp_axi_mem_model_if #(
  parameter int P_ID_W   = 4,
  parameter int P_DATA_W = 128
);
  // write address channel
  logic [P_ID_W-1:0]     i_awid;
  logic [31:0]           i_awaddr;
  logic [7:0]            i_awlen;
  logic                  i_awvalid;
  logic                  o_awready;
  // write data channel
  logic [P_DATA_W-1:0]   i_wdata;
  logic [P_DATA_W/8-1:0] i_wstrb;
  logic                  i_wlast;
  logic                  i_wvalid;
  logic                  o_wready;
  // write response channel
  logic [P_ID_W-1:0]     o_bid;
  logic                  o_bvalid;
  logic                  i_bready;
  // read address channel
  logic [P_ID_W-1:0]     i_arid;
  logic [31:0]           i_araddr;
  logic [7:0]            i_arlen;
  logic                  i_arvalid;
  logic                  o_arready;
  // read data channel
  logic [P_ID_W-1:0]     o_rid;
  logic [P_DATA_W-1:0]   o_rdata;
  logic                  o_rlast;
  logic                  o_rvalid;
  logic                  i_rready;

  modport slave (
    input  i_awid, i_awaddr, i_awlen, i_awvalid,
    output o_awready,
    input  i_wdata, i_wstrb, i_wlast, i_wvalid,
    output o_wready,
    output o_bid, o_bvalid,
    input  i_bready,
    input  i_arid, i_araddr, i_arlen, i_arvalid,
    output o_arready,
    output o_rid, o_rdata, o_rlast, o_rvalid,
    input  i_rready
  );

  modport master (
    output i_awid, i_awaddr, i_awlen, i_awvalid,
    input  o_awready,
    output i_wdata, i_wstrb, i_wlast, i_wvalid,
    input  o_wready,
    input  o_bid, o_bvalid,
    output i_bready,
    output i_arid, i_araddr, i_arlen, i_arvalid,
    input  o_arready,
    input  o_rid, o_rdata, o_rlast, o_rvalid,
    output i_rready
  );
endinterface

// File: rtl/pp_axi_mem_model.sv
// pp_axi_mem_model: word-addressed AXI slave RAM for the graphics core
// simulation top. One transaction in flight, INCR bursts only; the harness
// preloads/inspects the array `mem` hierarchically.
// Optional build macro PP_AXI_MEM_STALL_EN: a 16-bit LFSR randomly stalls
// AW/AR/W readiness and delays presentation of new R beats.
module pp_axi_mem_model #(
  parameter int P_ID_W   = 4,
  parameter int P_DATA_W = 128,
  parameter int P_MEM_AW = 16
) (
  input  logic                clk,
  input  logic                rst_x,
  pp_axi_mem_model_if.slave   bus,
  output logic [15:0]         o_err_cnt
);
  localparam int LP_B     = P_DATA_W / 8;
  localparam int LP_LB    = $clog2(LP_B);
  localparam int LP_DEPTH = 1 << P_MEM_AW;
  localparam logic [P_MEM_AW-1:0] LP_IDX_ONE = P_MEM_AW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WR    = 2'd1;
  localparam logic [1:0] S_WRESP = 2'd2;
  localparam logic [1:0] S_RD    = 2'd3;

  logic [P_DATA_W-1:0] mem [0:LP_DEPTH-1];

  logic [1:0]          state_r;
  logic [P_ID_W-1:0]   id_r;
  logic [P_MEM_AW-1:0] idx_r;
  logic [7:0]          len_r;
  logic [7:0]          cnt_r;
  logic                bvalid_r;
  logic                rvalid_r;
  logic                rlast_r;
  logic [P_DATA_W-1:0] rdata_r;
  logic [15:0]         err_cnt_r;

  logic                stall_s;
  logic                aw_ready_s, ar_ready_s, w_ready_s;
  logic                aw_fire_s, ar_fire_s, w_fire_s, rd_fire_s, rd_load_s;
  logic                last_beat_s;
  logic [P_MEM_AW-1:0] aw_idx_s, ar_idx_s;
  logic [P_DATA_W-1:0] wr_word_s;
  logic                unused_s;

`ifdef PP_AXI_MEM_STALL_EN
  logic [15:0] lfsr_r;

  // Free-running x^16+x^14+x^13+x^11+1 LFSR that decides stall cycles.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
    end
  end

  assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
  assign stall_s = 1'b0;
`endif

  // Only the word-index bits of the byte addresses select a location.
  assign unused_s = ^{bus.i_awaddr, bus.i_araddr};
  assign aw_idx_s = bus.i_awaddr[P_MEM_AW+LP_LB-1:LP_LB];
  assign ar_idx_s = bus.i_araddr[P_MEM_AW+LP_LB-1:LP_LB];

  // Channel readiness; reset forces everything low, writes win an AW/AR tie.
  always_comb begin
    aw_ready_s = 1'b0;
    ar_ready_s = 1'b0;
    w_ready_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        aw_ready_s = rst_x && !stall_s;
        ar_ready_s = rst_x && !stall_s && !(bus.i_awvalid && bus.i_arvalid);
      end
      S_WR: begin
        w_ready_s = rst_x && !stall_s;
      end
      default: begin
        aw_ready_s = 1'b0;
        ar_ready_s = 1'b0;
        w_ready_s  = 1'b0;
      end
    endcase
  end

  assign aw_fire_s   = aw_ready_s && bus.i_awvalid;
  assign ar_fire_s   = ar_ready_s && bus.i_arvalid;
  assign w_fire_s    = w_ready_s && bus.i_wvalid;
  assign last_beat_s = (cnt_r == len_r);
  assign rd_fire_s   = rvalid_r && bus.i_rready;
  // A new R beat is loaded when the slot is empty or the current beat is
  // being taken and more remain; a stall may only delay an empty slot.
  assign rd_load_s   = (state_r == S_RD) && !stall_s &&
                       (!rvalid_r || (bus.i_rready && !rlast_r));

  // Merge the strobed bytes of the incoming beat into the addressed word.
  always_comb begin
    wr_word_s = mem[idx_r];
    for (int b = 0; b < LP_B; b++) begin
      if (bus.i_wstrb[b]) begin
        wr_word_s[b*8 +: 8] = bus.i_wdata[b*8 +: 8];
      end else begin
        wr_word_s[b*8 +: 8] = mem[idx_r][b*8 +: 8];
      end
    end
  end

  // Memory array write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_fire_s) begin
      mem[idx_r] <= wr_word_s;
    end
  end

  // Transaction FSM with beat counting, responses and registered read data.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_r   <= S_IDLE;
      id_r      <= '0;
      idx_r     <= '0;
      len_r     <= 8'd0;
      cnt_r     <= 8'd0;
      bvalid_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rdata_r   <= '0;
      err_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (aw_fire_s) begin
            id_r    <= bus.i_awid;
            idx_r   <= aw_idx_s;
            len_r   <= bus.i_awlen;
            cnt_r   <= 8'd0;
            state_r <= S_WR;
          end else if (ar_fire_s) begin
            id_r     <= bus.i_arid;
            idx_r    <= ar_idx_s + LP_IDX_ONE;
            len_r    <= bus.i_arlen;
            cnt_r    <= 8'd0;
            rdata_r  <= mem[ar_idx_s];
            rvalid_r <= 1'b1;
            rlast_r  <= (bus.i_arlen == 8'd0);
            state_r  <= S_RD;
          end
        end
        S_WR: begin
          if (w_fire_s) begin
            idx_r <= idx_r + LP_IDX_ONE;
            cnt_r <= cnt_r + 8'd1;
            // WLAST disagreeing with the beat count is logged, not obeyed.
            if ((bus.i_wlast != last_beat_s) && (err_cnt_r != 16'hFFFF)) begin
              err_cnt_r <= err_cnt_r + 16'd1;
            end
            if (last_beat_s) begin
              bvalid_r <= 1'b1;
              state_r  <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (bus.i_bready) begin
            bvalid_r <= 1'b0;
            state_r  <= S_IDLE;
          end
        end
        S_RD: begin
          if (rd_load_s) begin
            rdata_r  <= mem[idx_r];
            rvalid_r <= 1'b1;
            rlast_r  <= ((cnt_r + 8'd1) == len_r);
            idx_r    <= idx_r + LP_IDX_ONE;
            cnt_r    <= cnt_r + 8'd1;
          end else if (rd_fire_s) begin
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            if (rlast_r) begin
              state_r <= S_IDLE;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_awready = aw_ready_s;
  assign bus.o_arready = ar_ready_s;
  assign bus.o_wready  = w_ready_s;
  assign bus.o_bid     = id_r;
  assign bus.o_bvalid  = bvalid_r;
  assign bus.o_rid     = id_r;
  assign bus.o_rdata   = rdata_r;
  assign bus.o_rlast   = rlast_r;
  assign bus.o_rvalid  = rvalid_r;
  assign o_err_cnt     = err_cnt_r;
endmodule

// File: tb/tb_pp_axi_mem_model.sv
// tb_pp_axi_mem_model: directed + randomized bench for pp_axi_mem_model.
// A plain array of words, indexed by (byte address / 16 + beat) mod 65536,
// serves as the reference memory.
module tb_pp_axi_mem_model;
  logic        clk;
  logic        rst_x;
  logic [15:0] err_cnt;
  int          checks;
  int          errors;

  logic [127:0] model_mem [0:65535];

  pp_axi_mem_model_if #(.P_ID_W(4), .P_DATA_W(128)) bus ();

  pp_axi_mem_model #(.P_ID_W(4), .P_DATA_W(128), .P_MEM_AW(16)) dut (
    .clk      (clk),
    .rst_x    (rst_x),
    .bus      (bus),
    .o_err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int widx(input logic [31:0] a, input int k);
    return (int'(a[31:4]) + k) & 32'h0000_FFFF;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len);
    logic rdy;
    int   n;
    bus.i_awid    = id;
    bus.i_awaddr  = addr;
    bus.i_awlen   = 8'(len);
    bus.i_awvalid = 1'b1;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 50) begin
      #1;
      rdy = bus.o_awready;
      @(negedge clk);
      n++;
    end
    bus.i_awvalid = 1'b0;
    check("aw_accept", 128'(rdy), 128'(1'b1));
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len);
    logic rdy;
    int   n;
    bus.i_arid    = id;
    bus.i_araddr  = addr;
    bus.i_arlen   = 8'(len);
    bus.i_arvalid = 1'b1;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 50) begin
      #1;
      rdy = bus.o_arready;
      @(negedge clk);
      n++;
    end
    bus.i_arvalid = 1'b0;
    check("ar_accept", 128'(rdy), 128'(1'b1));
  endtask

  // dmode: 0 random, 1 counting 1..N, 2 zero. smode: 0 full, 1 random, 2 byte 0 only.
  task automatic write_data(input logic [31:0] addr, input int len, input int dmode,
                            input int smode, input int early);
    logic [127:0] d;
    logic [15:0]  s;
    logic         rdy;
    int           n;
    for (int k = 0; k <= len; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.i_wvalid = 1'b0;
        @(negedge clk);
      end
      case (dmode)
        0:       d = {$urandom, $urandom, $urandom, $urandom};
        1:       d = 128'(k + 1);
        default: d = 128'd0;
      endcase
      case (smode)
        0:       s = 16'hFFFF;
        1:       s = 16'($urandom);
        default: s = 16'h0001;
      endcase
      bus.i_wdata  = d;
      bus.i_wstrb  = s;
      bus.i_wlast  = (k == len) || (k == early);
      bus.i_wvalid = 1'b1;
      rdy = 1'b0;
      n   = 0;
      while (!rdy && n < 50) begin
        #1;
        rdy = bus.o_wready;
        @(negedge clk);
        n++;
      end
      check("w_accept", 128'(rdy), 128'(1'b1));
      for (int b = 0; b < 16; b++) begin
        if (s[b]) model_mem[widx(addr, k)][b*8 +: 8] = d[b*8 +: 8];
      end
      if (k < len) begin
        #1;
        check("bvalid_early", 128'(bus.o_bvalid), 128'(1'b0));
      end
    end
    bus.i_wvalid = 1'b0;
    bus.i_wlast  = 1'b0;
  endtask

  task automatic wait_b(input logic [3:0] id, input int hold);
    #1;
    check("b_latency", 128'(bus.o_bvalid), 128'(1'b1));
    check("bid", 128'(bus.o_bid), 128'(id));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("b_hold", 128'(bus.o_bvalid), 128'(1'b1));
    end
    @(negedge clk);
    bus.i_bready = 1'b1;
    @(negedge clk);
    bus.i_bready = 1'b0;
    #1;
    check("b_done", 128'(bus.o_bvalid), 128'(1'b0));
  endtask

  // mode: 0 rready always high, 1 toggling 1010..., 2 random.
  task automatic read_beats(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int mode);
    int   k;
    int   cyc;
    logic rr;
    logic v;
    k   = 0;
    cyc = 0;
    while (k <= len && cyc < 2000) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      bus.i_rready = rr;
      #1;
      v = bus.o_rvalid;
      check("rvalid", 128'(v), 128'(1'b1));
      check("rdata", bus.o_rdata, model_mem[widx(addr, k)]);
      check("rlast", 128'(bus.o_rlast), 128'(k == len));
      check("rid", 128'(bus.o_rid), 128'(id));
      @(negedge clk);
      cyc++;
      if (rr && v) k++;
    end
    bus.i_rready = 1'b0;
    check("r_beats", 128'(k), 128'(len + 1));
    #1;
    check("rvalid_after", 128'(bus.o_rvalid), 128'(1'b0));
  endtask

  initial begin
    logic [127:0] w;
    logic [31:0]  a;
    logic [3:0]   id;
    int           len;
    checks = 0;
    errors = 0;
    rst_x  = 1'b0;
    bus.i_awid = '0; bus.i_awaddr = '0; bus.i_awlen = '0; bus.i_awvalid = 1'b0;
    bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wlast = 1'b0; bus.i_wvalid = 1'b0;
    bus.i_bready = 1'b0;
    bus.i_arid = '0; bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arvalid = 1'b0;
    bus.i_rready = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      dut.mem[i]   = w;
      model_mem[i] = w;
    end

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_awready", 128'(bus.o_awready), 128'(1'b0));
    check("rst_arready", 128'(bus.o_arready), 128'(1'b0));
    check("rst_bvalid", 128'(bus.o_bvalid), 128'(1'b0));
    check("rst_rvalid", 128'(bus.o_rvalid), 128'(1'b0));
    check("rst_rdata", bus.o_rdata, 128'd0);
    check("rst_err", 128'(err_cnt), 128'd0);
    @(negedge clk);
    rst_x = 1'b1;
    #1;
    check("idle_awready", 128'(bus.o_awready), 128'(1'b1));
    check("idle_arready", 128'(bus.o_arready), 128'(1'b1));
    @(negedge clk);

    // basic write 1..4 then read back
    send_aw(4'h3, 32'h0000_0100, 3);
    write_data(32'h0000_0100, 3, 1, 0, -1);
    wait_b(4'h3, 0);
    send_ar(4'h9, 32'h0000_0100, 3);
    read_beats(4'h9, 32'h0000_0100, 3, 0);

    // partial strobe on a preloaded all-ones word
    dut.mem[16'h0010]   = '1;
    model_mem[16'h0010] = '1;
    send_aw(4'h1, 32'h0000_0100, 0);
    write_data(32'h0000_0100, 0, 2, 2, -1);
    wait_b(4'h1, 2);
    check("partial_model", model_mem[16'h0010], {{120{1'b1}}, 8'h00});
    send_ar(4'h2, 32'h0000_0100, 0);
    read_beats(4'h2, 32'h0000_0100, 0, 0);

    // AW and AR together: write first, read after B
    @(negedge clk);
    bus.i_arid = 4'h7; bus.i_araddr = 32'h0000_0200; bus.i_arlen = 8'd1; bus.i_arvalid = 1'b1;
    bus.i_awid = 4'h2; bus.i_awaddr = 32'h0000_0200; bus.i_awlen = 8'd1; bus.i_awvalid = 1'b1;
    #1;
    check("tie_awready", 128'(bus.o_awready), 128'(1'b1));
    check("tie_arready", 128'(bus.o_arready), 128'(1'b0));
    send_aw(4'h2, 32'h0000_0200, 1);
    #1;
    check("ar_blocked_wr", 128'(bus.o_arready), 128'(1'b0));
    write_data(32'h0000_0200, 1, 0, 0, -1);
    #1;
    check("ar_blocked_wresp", 128'(bus.o_arready), 128'(1'b0));
    wait_b(4'h2, 1);
    send_ar(4'h7, 32'h0000_0200, 1);
    read_beats(4'h7, 32'h0000_0200, 1, 0);

    // len 7 read with rready toggling
    send_ar(4'h4, 32'h0000_1000, 7);
    read_beats(4'h4, 32'h0000_1000, 7, 1);

    // early WLAST: one error, burst still ends on the fourth beat
    send_aw(4'hA, 32'h0000_0300, 3);
    write_data(32'h0000_0300, 3, 0, 0, 1);
    wait_b(4'hA, 0);
    check("err_cnt_one", 128'(err_cnt), 128'd1);
    send_ar(4'hB, 32'h0000_0300, 3);
    read_beats(4'hB, 32'h0000_0300, 3, 2);

    // reset in the middle of a read burst
    send_ar(4'h5, 32'h0000_0100, 7);
    bus.i_rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.i_rready = 1'b0;
    rst_x = 1'b0;
    #1;
    check("abort_rvalid", 128'(bus.o_rvalid), 128'(1'b0));
    check("abort_rlast", 128'(bus.o_rlast), 128'(1'b0));
    check("abort_err", 128'(err_cnt), 128'd0);
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);
    send_ar(4'h6, 32'h0000_0300, 3);
    read_beats(4'h6, 32'h0000_0300, 3, 0);

    // 256-beat burst wrapping past the top of memory
    send_aw(4'hC, 32'h000F_FF80, 255);
    write_data(32'h000F_FF80, 255, 0, 1, -1);
    wait_b(4'hC, 0);
    send_ar(4'hD, 32'h000F_FF80, 255);
    read_beats(4'hD, 32'h000F_FF80, 255, 2);

    // randomized write/read pairs over the whole 32-bit address space
    for (int t = 0; t < 20; t++) begin
      a   = $urandom;
      id  = 4'($urandom);
      len = $urandom_range(0, 15);
      send_aw(id, a, len);
      write_data(a, len, 0, 1, -1);
      wait_b(id, $urandom_range(0, 2));
      a   = a + 32'(16 * $urandom_range(0, 8));
      id  = 4'($urandom);
      len = $urandom_range(0, 15);
      send_ar(id, a, len);
      read_beats(id, a, len, 2);
    end
    check("err_cnt_final", 128'(err_cnt), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pp_axi_mem_model.md
Name: pp_axi_mem_model

Overview:
- Synthesizable AXI slave memory that sits directly downstream of the graphics core's AXI master port in the Verilator simulation top; it serves the core's framebuffer and texture reads and writes.
- Word-addressed RAM, one transaction in flight at a time, INCR bursts only.
- The harness preloads and inspects it through hierarchical access to the array `mem`.

Parameters:
- P_ID_W, 4: width of the ID fields.
- P_DATA_W, 128: data beat width in bits; must be a power of two, at least 32. Byte lanes B = P_DATA_W/8.
- P_MEM_AW, 16: log2 of the word depth. Word index = addr[P_MEM_AW+log2(B)-1 : log2(B)], wrapping modulo 2^P_MEM_AW.

Ports:
- clk  in  1  clock, shared by all channels
- rst_x  in  1  reset, asynchronous, active-low
- i_awid  in  P_ID_W  write address ID
- i_awaddr  in  32  write byte address
- i_awlen  in  8  write beats minus 1
- i_awvalid  in  1  write address valid
- o_awready  out  1  write address accepted
- i_wdata  in  P_DATA_W  write data
- i_wstrb  in  B  byte enables
- i_wlast  in  1  final write beat
- i_wvalid  in  1  write data valid
- o_wready  out  1  write data accepted
- o_bid  out  P_ID_W  echoed AW ID
- o_bvalid  out  1  write response valid; BRESP is tied to OKAY by the instantiator
- i_bready  in  1  write response taken
- i_arid  in  P_ID_W  read address ID
- i_araddr  in  32  read byte address
- i_arlen  in  8  read beats minus 1
- i_arvalid  in  1  read address valid
- o_arready  out  1  read address accepted
- o_rid  out  P_ID_W  echoed AR ID
- o_rdata  out  P_DATA_W  read data
- o_rlast  out  1  final read beat
- o_rvalid  out  1  read data valid; RRESP is tied to OKAY by the instantiator
- i_rready  in  1  read data taken
- o_err_cnt  out  16  protocol error count

Behaviour:
- Reset: all outputs 0. FSM returns to IDLE. Beat counters cleared. Memory contents are not reset. Asserting rst_x low mid-burst aborts the burst immediately, with no B or R response.
- FSM states: IDLE, WR, WRESP, RD.
- IDLE: o_awready = o_arready = 1 combinationally, except when both i_awvalid and i_arvalid are high. In that case only o_awready is high: writes win.
  - AW handshake: latch id, word index and len; go to WR.
  - AR handshake: latch id, word index and len; go to RD.
- WR: o_wready = 1.
  - Each W handshake writes the bytes enabled by i_wstrb to mem[idx], then increments idx (wrapping) and the beat count.
  - The beat where count == len ends the burst: go to WRESP.
  - i_wlast must match count == len. On mismatch, increment o_err_cnt (saturating at 0xFFFF); the burst still ends at count == len.
- WRESP: o_bvalid = 1 and o_bid = latched id, held until i_bready. Then return to IDLE. B response latency is 1 cycle after the last W beat.
- RD:
  - o_rdata is registered: the first beat becomes valid in the cycle after the AR handshake.
  - o_rvalid, o_rdata, o_rid and o_rlast stay stable while i_rready is low.
  - On each R handshake, present the next word in the following cycle. Back-to-back beats run at 1 per cycle while i_rready is held high.
  - o_rlast is high on beat len. Its handshake returns the FSM to IDLE.
- A write to idx followed by a read of idx returns the new data; there is no bypass hazard because transactions are serialized.
- len = 0 means a single beat. len = 255 means 256 beats and wraps past the top of memory.

Optional Feature:
- PP_AXI_MEM_STALL_EN: when defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1, reset to the seed, advancing every cycle) gates readiness.
  - o_awready, o_arready and o_wready are forced low, and o_rvalid is held off before a new beat is presented, on cycles where lfsr[1:0] == 0.
  - Stalls never retract o_rvalid once it is asserted.
- When undefined: no LFSR is built and the timing is exactly as specified above.

Test Plan:
- Write addr 0x100, len 3, data 1..4, full strobes; read back -> four R beats 1,2,3,4, o_rlast on beat 4, o_rid equals i_arid, first beat 1 cycle after the AR handshake.
- Partial strobe: mem[0x10] preloaded 0xFFFF...; write wstrb = 0x0001, wdata = 0 -> readback low byte 0x00, other bytes 0xFF.
- AW and AR valid in the same cycle -> write accepted first, AR accepted only after the B handshake; read returns the newly written data.
- i_rready toggled 1010... on a len 7 read -> 8 beats, with o_rdata and o_rlast stable during stalls.
- i_wlast asserted on beat 2 of a len 3 burst -> o_err_cnt = 1, B after beat 4. Then rst_x pulsed low mid-read -> o_rvalid = 0 immediately, next AR serviced normally.
